daq_fifo_wr_ctrl: RTL
=====================

DAQ_FIFO_WR_CTRL -- requirements
Module: daq_fifo_wr_ctrl

Interface
REQ-001 Parameter NSAMP, default 8: sample words per event, legal range 1..255.
REQ-002 Parameter DW, default 16: FIFO data width; DW SHALL be at least 16.
REQ-003 CLK  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 FIFO_DONE  input  1  high when the DAQ FIFO reset sequence has completed and the FIFO is usable.
REQ-006 FIFO_RST  input  1  high while the DAQ FIFO is being reset.
REQ-007 L1A  input  1  single-cycle trigger pulse.
REQ-008 SAMP_VLD  input  1  qualifies SAMP_DATA.
REQ-009 SAMP_DATA  input  DW  ADC sample word.
REQ-010 FIFO_AFULL  input  1  FIFO almost full; the FIFO has room for at least NSAMP+2 words while this is low.
REQ-011 FIFO_FULL  input  1  FIFO full.
REQ-012 WR_EN  output  1  registered FIFO write strobe.
REQ-013 WR_DATA  output  DW  registered FIFO write word.
REQ-014 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-015 EVT_CNT  output  12  count of L1A pulses seen while ready.
REQ-016 DROP_CNT  output  8  events dropped because FIFO_AFULL was high; saturates at 255.
REQ-017 MISS_CNT  output  8  L1A pulses received while BUSY; saturates at 255.
REQ-018 OVFL  output  1  sticky flag: a write was suppressed because FIFO_FULL was high.

Function
REQ-019 The FSM SHALL have the states WAIT_RDY, IDLE, HEADER, SAMPLES, TRAILER and DROP.
REQ-020 WAIT_RDY SHALL go to IDLE when FIFO_DONE=1 and FIFO_RST=0.
REQ-021 FIFO_RST=1 in any state SHALL force WAIT_RDY on the next edge, abandon any partial frame, and clear OVFL; the counters SHALL be retained.
REQ-022 IDLE with L1A=1 SHALL increment EVT_CNT (wrapping 4095->0); it SHALL go to HEADER if FIFO_AFULL=0, otherwise to DROP.
REQ-023 DROP SHALL increment DROP_CNT (saturating at 255), write nothing, and return to IDLE after one cycle.
REQ-024 HEADER SHALL write one word, {4'hA, EVT_CNT value after increment}, zero-extended to DW, then go to SAMPLES.
REQ-025 SAMPLES SHALL write SAMP_DATA on each cycle with SAMP_VLD=1 and hold while SAMP_VLD=0.
REQ-026 SAMPLES SHALL go to TRAILER after NSAMP words have been written; the sample counter SHALL be 8 bits and cleared in HEADER.
REQ-027 TRAILER SHALL write one word, {4'hE, 4'h0, number of sample words actually written[7:0]}, zero-extended to DW, then return to IDLE.
REQ-028 WR_EN and WR_DATA SHALL be registered, with WR_EN asserted in the cycle after the state or sample is qualified; the header word therefore appears 2 cycles after L1A.
REQ-029 When FIFO_FULL=1 in a cycle that would write, WR_EN SHALL stay low, OVFL SHALL set, and the sample counter SHALL still advance, so frame length in cycles is unchanged.
REQ-030 When FIFO_FULL=1 suppresses a sample write, that sample SHALL NOT be included in the trailer count.
REQ-031 An L1A pulse in any state other than IDLE and WAIT_RDY SHALL increment MISS_CNT (saturating) and leave EVT_CNT unchanged.
REQ-032 An L1A pulse in WAIT_RDY SHALL be ignored entirely.
REQ-033 L1A arriving in the same cycle the FSM returns from TRAILER or DROP to IDLE SHALL be counted as missed.
REQ-034 WR_DATA SHALL hold its last value while WR_EN=0.

Reset
REQ-035 RST_N=0 SHALL asynchronously set the state to WAIT_RDY and drive WR_EN=0, WR_DATA=0, BUSY=1, EVT_CNT=0, DROP_CNT=0, MISS_CNT=0, OVFL=0, and the sample counter to 0.
REQ-036 Reset release SHALL take effect on the first CLK edge after RST_N goes high; no write SHALL occur before FIFO_DONE is seen.

Verification
REQ-037 Reset, then FIFO_DONE=1, then L1A, then 8 cycles of continuous SAMP_VLD -> exactly 10 writes: 0x A001, the 8 samples, then 0x E008; BUSY returns low.
REQ-038 FIFO_AFULL=1 at L1A -> no writes, DROP_CNT=1, EVT_CNT=1; the next L1A with FIFO_AFULL=0 produces header 0xA002.
REQ-039 L1A repeated 3 times during SAMPLES -> MISS_CNT=3, EVT_CNT unchanged; 300 such pulses -> MISS_CNT holds at 255.
REQ-040 FIFO_FULL=1 for 2 sample cycles -> 2 writes suppressed, OVFL=1, trailer 0xE006; a FIFO_RST pulse clears OVFL and returns the FSM to WAIT_RDY.
REQ-041 FIFO_RST asserted mid-SAMPLES -> WR_EN low from the next cycle, no trailer written, BUSY=1 until FIFO_DONE=1 with FIFO_RST=0.
REQ-042 4096 accepted events -> EVT_CNT wraps to 0, and the following header is 0xA001.

Source files
------------

// File: rtl/daq_fifo_wr_ctrl.sv
// DAQ FIFO write controller.
// Builds one frame per accepted trigger: a header word with the event number,
// NSAMP sample words, and a trailer word holding the count of samples that
// actually reached the FIFO. Triggers are dropped when the FIFO is almost full
// and counted as missed while a frame is in progress.
module daq_fifo_wr_ctrl #(
    parameter int NSAMP = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_done,
    input  logic          fifo_rst,
    input  logic          l1a,
    input  logic          samp_vld,
    input  logic [DW-1:0] samp_data,
    input  logic          fifo_afull,
    input  logic          fifo_full,
    output logic          wr_en,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic [11:0]   evt_cnt,
    output logic [7:0]    drop_cnt,
    output logic [7:0]    miss_cnt,
    output logic          ovfl
);

    localparam logic [2:0] WAIT_RDY = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] HEADER   = 3'd2;
    localparam logic [2:0] SAMPLES  = 3'd3;
    localparam logic [2:0] TRAILER  = 3'd4;
    localparam logic [2:0] DROP     = 3'd5;

    // Index of the last sample slot in a frame.
    localparam logic [7:0] LAST_SAMP = 8'(NSAMP - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [7:0]    samp_cnt;   // sample slots consumed, written or suppressed
    logic [7:0]    wr_cnt;     // sample words that actually reached the FIFO
    logic          wr_req;     // this cycle would produce a FIFO word
    logic          wr_ok;      // ... and the FIFO can take it
    logic [DW-1:0] wr_word;

    assign busy  = (state != IDLE);
    assign wr_ok = wr_req & ~fifo_full;

    // Next-state decode; a FIFO reset overrides everything else.
    always_comb begin
        state_nxt = state;
        if (fifo_rst) begin
            state_nxt = WAIT_RDY;
        end else begin
            case (state)
                WAIT_RDY: if (fifo_done) state_nxt = IDLE;
                IDLE:     if (l1a) state_nxt = fifo_afull ? DROP : HEADER;
                HEADER:   state_nxt = SAMPLES;
                SAMPLES:  if (samp_vld && samp_cnt == LAST_SAMP) state_nxt = TRAILER;
                TRAILER:  state_nxt = IDLE;
                DROP:     state_nxt = IDLE;
                default:  state_nxt = WAIT_RDY;
            endcase
        end
    end

    // Select the word this state wants to write; words are 16 bits zero-extended to DW.
    always_comb begin
        wr_req  = 1'b0;
        wr_word = wr_data;
        if (!fifo_rst) begin
            case (state)
                HEADER: begin
                    wr_req  = 1'b1;
                    wr_word = DW'({4'hA, evt_cnt});
                end
                SAMPLES: begin
                    if (samp_vld) begin
                        wr_req  = 1'b1;
                        wr_word = samp_data;
                    end
                end
                TRAILER: begin
                    wr_req  = 1'b1;
                    wr_word = DW'({4'hE, 4'h0, wr_cnt});
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_RDY;
        else        state <= state_nxt;
    end

    // Registered write port; data holds its last value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_en <= wr_ok;
            if (wr_ok) wr_data <= wr_word;
        end
    end

    // Sample slot and written-word counters; suppressed writes still use a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= 8'd0;
            wr_cnt   <= 8'd0;
        end else if (state == HEADER) begin
            samp_cnt <= 8'd0;
            wr_cnt   <= 8'd0;
        end else if (state == SAMPLES && samp_vld && !fifo_rst) begin
            samp_cnt <= samp_cnt + 8'd1;
            if (wr_ok) wr_cnt <= wr_cnt + 8'd1;
        end
    end

    // Sticky overflow: set on any write blocked by a full FIFO, cleared by FIFO reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    ovfl <= 1'b0;
        else if (fifo_rst)             ovfl <= 1'b0;
        else if (wr_req && fifo_full)  ovfl <= 1'b1;
    end

    // Event counter wraps; it advances only for triggers taken in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                evt_cnt <= 12'd0;
        else if (state == IDLE && l1a && !fifo_rst) evt_cnt <= evt_cnt + 12'd1;
    end

    // Saturating drop counter, one count per DROP visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 drop_cnt <= 8'd0;
        else if (state == DROP && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end

    // Saturating miss counter for triggers arriving while a frame or drop is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= 8'd0;
        end else if (l1a && state != IDLE && state != WAIT_RDY && miss_cnt != 8'hFF) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end

endmodule
